present_kschd: RTL and testbench

//  PRESENT-80 key-schedule controller. Sits directly upstream of the 80-bit key register.
//  - Drives the register's start/active/initial/next inputs; consumes its output.
//  - Issues round keys K1..K32 to the round datapath over a valid/ready handshake.
//  - Computes the next key state combinationally from the register output.

---
 rtl/present_kschd.sv | 112 +++++++++++
 tb/tb_present_kschd.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_kschd.sv
// PRESENT-80 key-schedule controller: drives an external 80-bit key register and issues
// round keys over valid/ready. Optional macro KSCHD_LASTKEY_EN adds the last_key capture port.
module present_kschd #(
    parameter int NRND = 32
) (
    input  logic        ck,
    input  logic        rn,
    input  logic        start,
    input  logic        abort,
    input  logic [0:79] key_in,
    input  logic [0:79] kreg_q,
    output logic        kreg_sta,
    output logic        kreg_act,
    output logic [0:79] kreg_inp,
    output logic [0:79] kreg_nxt,
    output logic [0:63] rk_out,
    output logic        rk_vld,
    input  logic        rk_rdy,
    output logic [4:0]  rnd,
    output logic        busy,
`ifdef KSCHD_LASTKEY_EN
    output logic [0:79] last_key,
`endif
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} st_t;

    localparam logic [5:0] NR = 6'(NRND);

    st_t        st, st_nx;
    logic [5:0] cnt, cnt_nx;
    logic       cap;
    logic [0:79] t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    assign kreg_sta = start;
    assign kreg_inp = key_in;
    assign rk_out   = kreg_q[0:63];
    // Counter is 6 bits so it can reach NRND=32; the port shows the low 5 bits (K32 reads as 0).
    assign rnd      = cnt[4:0];

    always_comb begin
        t        = {kreg_q[61:79], kreg_q[0:60]};
        t[0:3]   = sbox(t[0:3]);
        t[60:64] = t[60:64] ^ cnt[4:0];
        kreg_nxt = t;
    end

    always_comb begin
        st_nx    = st;
        cnt_nx   = cnt;
        kreg_act = 1'b0;
        cap      = 1'b0;
        rk_vld   = (st == RUN);
        busy     = (st == RUN);
        done     = (st == FIN);
        if (start) begin
            st_nx  = RUN;
            cnt_nx = 6'd1;
        end else if (abort) begin
            st_nx  = IDLE;
            cnt_nx = 6'd0;
        end else begin
            case (st)
                RUN: begin
                    if (rk_rdy) begin
                        if (cnt < NR) begin
                            kreg_act = 1'b1;
                            cnt_nx   = cnt + 6'd1;
                        end else begin
                            cap    = 1'b1;
                            st_nx  = FIN;
                            cnt_nx = 6'd0;
                        end
                    end
                end
                FIN:     st_nx = IDLE;
                default: st_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            st  <= IDLE;
            cnt <= 6'd0;
        end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
        end
    end

`ifdef KSCHD_LASTKEY_EN
    // Final key state kept for seeding a decryption run.
    always_ff @(posedge ck or negedge rn) begin
        if (!rn)
            last_key <= '0;
        else if (cap)
            last_key <= kreg_q;
    end
`endif

endmodule

// File: tb/tb_present_kschd.sv
// Scoreboard bench for present_kschd: golden PRESENT-80 key schedule pushed at start,
// popped on every round-key handshake; includes a behavioural model of the key register.
module tb_present_kschd;

    localparam int NRND = 32;

    logic        ck, rn, start, abort, rk_rdy;
    logic [0:79] key_in, kreg_q, kreg_inp, kreg_nxt;
    logic        kreg_sta, kreg_act, rk_vld, busy, done;
    logic [0:63] rk_out;
    logic [4:0]  rnd;
`ifdef KSCHD_LASTKEY_EN
    logic [0:79] last_key;
`endif

    int tests_run = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    logic [79:0] gold_last;

    present_kschd #(.NRND(NRND)) dut (
        .ck(ck), .rn(rn), .start(start), .abort(abort), .key_in(key_in), .kreg_q(kreg_q),
        .kreg_sta(kreg_sta), .kreg_act(kreg_act), .kreg_inp(kreg_inp), .kreg_nxt(kreg_nxt),
        .rk_out(rk_out), .rk_vld(rk_vld), .rk_rdy(rk_rdy), .rnd(rnd), .busy(busy),
`ifdef KSCHD_LASTKEY_EN
        .last_key(last_key),
`endif
        .done(done)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // external key register, cleared by the same reset
    always @(posedge ck or negedge rn) begin
        if (!rn)           kreg_q <= '0;
        else if (kreg_sta) kreg_q <= kreg_inp;
        else if (kreg_act) kreg_q <= kreg_nxt;
    end

    function automatic logic [3:0] gsb(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'hC56B90AD3EF84712;
        return tbl[63 - 4*x -: 4];
    endfunction

    function automatic logic [79:0] gnext(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = gsb(t[79:76]);
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction

    function automatic logic [79:0] rkey();
        return 80'({$urandom, $urandom, $urandom});
    endfunction

    task automatic push_gold(input logic [79:0] key);
        logic [79:0] k;
        k = key;
        exp_q.delete();
        for (int r = 1; r <= NRND; r++) begin
            exp_q.push_back(k[79:16]);
            if (r == NRND) gold_last = k;
            k = gnext(k, 5'(r));
        end
    endtask

    task automatic pulse_start(input logic [79:0] key);
        @(negedge ck);
        key_in = key;
        start  = 1'b1;
        push_gold(key);
        @(posedge ck);
        #1 start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge ck);
        abort = 1'b1;
        @(posedge ck);
        #1 abort = 1'b0;
    endtask

    // run with rk_rdy=1 until rnd reaches target; returns 1 if reached
    task automatic run_to(input logic [4:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge ck);
            rk_rdy = 1'b1;
            #1;
            if (rnd == target) begin
                ok = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!ok) begin
            fails++;
            $display("FAIL run_to timeout: rnd=%0d required=%0d", rnd, target);
        end
    endtask

    task automatic run_keys(input bit rand_rdy, input bit chk_lat);
        int cyc = 0, acts = 0, dones = 0, er = 1;
        bit pstall = 1'b0;
        logic [63:0] pout, e;
        logic [4:0] prnd;
        while (dones == 0 && cyc < 400) begin
            @(negedge ck);
            cyc++;
            rk_rdy = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (pstall && rk_vld) begin
                tests_run++;
                if (rk_out !== pout || rnd !== prnd) begin
                    fails++;
                    $display("FAIL stall_hold: key=%h rnd=%0d required key=%h rnd=%0d",
                             rk_out, rnd, pout, prnd);
                end
            end
            if (rk_vld && !rk_rdy) begin
                tests_run++;
                if (kreg_act !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_act: kreg_act=%b required=0", kreg_act);
                end
            end
            if (rk_vld && rk_rdy) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_key: key=%h rnd=%0d required none", rk_out, rnd);
                end else begin
                    e = exp_q.pop_front();
                    if (rk_out !== e || rnd !== 5'(er)) begin
                        fails++;
                        $display("FAIL key%0d: key=%h rnd=%0d required key=%h rnd=%0d",
                                 er, rk_out, rnd, e, 5'(er));
                    end
                end
                er++;
            end
            if (kreg_act === 1'b1) acts++;
            if (done === 1'b1) begin
                dones++;
                if (chk_lat) begin
                    tests_run++;
                    if (cyc != NRND + 1) begin
                        fails++;
                        $display("FAIL done_latency: cycle=%0d required=%0d", cyc, NRND + 1);
                    end
                end
            end
            pstall = rk_vld && !rk_rdy;
            pout   = rk_out;
            prnd   = rnd;
        end
        tests_run++;
        if (dones != 1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL run_end: dones=%0d keys_left=%0d required 1 and 0", dones, exp_q.size());
        end
        tests_run++;
        if (acts != NRND - 1) begin
            fails++;
            $display("FAIL act_count: count=%0d required=%0d", acts, NRND - 1);
        end
        @(negedge ck);
        #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || rk_vld !== 1'b0 || rnd !== 5'd0) begin
            fails++;
            $display("FAIL after_done: done=%b busy=%b vld=%b rnd=%0d required 0 0 0 0",
                     done, busy, rk_vld, rnd);
        end
    endtask

    task automatic test_reset();
        rn = 1'b0; start = 1'b0; abort = 1'b0; rk_rdy = 1'b0; key_in = '0;
        repeat (2) @(posedge ck);
        #1;
        tests_run++;
        if (rk_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rnd !== 5'd0 || kreg_act !== 1'b0) begin
            fails++;
            $display("FAIL reset: vld=%b busy=%b done=%b rnd=%0d act=%b required all 0",
                     rk_vld, busy, done, rnd, kreg_act);
        end
`ifdef KSCHD_LASTKEY_EN
        tests_run++;
        if (last_key !== 80'h0) begin
            fails++;
            $display("FAIL reset_lastkey: last_key=%h required 0", last_key);
        end
`endif
        @(negedge ck);
        rn = 1'b1;
    endtask

    task automatic test_known_vector();
        pulse_start(80'h0);
        @(negedge ck);
        rk_rdy = 1'b1;
        #1;
        tests_run++;
        if (rk_out !== 64'h0 || rnd !== 5'd1 || rk_vld !== 1'b1 || kreg_act !== 1'b1) begin
            fails++;
            $display("FAIL k1_zero: key=%h rnd=%0d vld=%b act=%b required 0 1 1 1",
                     rk_out, rnd, rk_vld, kreg_act);
        end
        @(negedge ck);
        #1;
        tests_run++;
        if (rk_out !== 64'hC000000000000000 || kreg_q !== 80'hC0000000000000008000 || rnd !== 5'd2) begin
            fails++;
            $display("FAIL k2_zero: key=%h kreg=%h rnd=%0d required C000000000000000 C0000000000000008000 2",
                     rk_out, kreg_q, rnd);
        end
        do_abort();
    endtask

    task automatic test_full();
        pulse_start({80{1'b1}});
        run_keys(1'b0, 1'b1);
    endtask

    task automatic test_stall();
        pulse_start({80{1'b1}});
        run_keys(1'b1, 1'b0);
    endtask

    task automatic test_abort_restart();
        bit ok;
        int dn = 0;
        logic [79:0] k;
        pulse_start(rkey());
        run_to(5'd7, ok);
        abort = 1'b1;
        #1;
        tests_run++;
        if (kreg_act !== 1'b0) begin
            fails++;
            $display("FAIL abort_act: kreg_act=%b required 0", kreg_act);
        end
        @(posedge ck);
        #1 abort = 1'b0;
        tests_run++;
        if (rk_vld !== 1'b0 || busy !== 1'b0 || rnd !== 5'd0) begin
            fails++;
            $display("FAIL abort: vld=%b busy=%b rnd=%0d required 0 0 0", rk_vld, busy, rnd);
        end
        repeat (40) begin
            @(negedge ck);
            if (done === 1'b1) dn++;
        end
        tests_run++;
        if (dn != 0) begin
            fails++;
            $display("FAIL abort_done: pulses=%0d required 0", dn);
        end
        k = rkey();
        pulse_start(k);
        run_to(5'd12, ok);
        start = 1'b1;
        push_gold(k);
        #1;
        tests_run++;
        if (kreg_act !== 1'b0 || kreg_sta !== 1'b1) begin
            fails++;
            $display("FAIL restart_act: act=%b sta=%b required 0 1", kreg_act, kreg_sta);
        end
        @(posedge ck);
        #1 start = 1'b0;
        tests_run++;
        if (rnd !== 5'd1 || rk_out !== exp_q[0] || rk_vld !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL restart: key=%h rnd=%0d vld=%b done=%b required key=%h 1 1 0",
                     rk_out, rnd, rk_vld, done, exp_q[0]);
        end
        do_abort();
    endtask

    task automatic test_reset_midrun();
        bit ok;
        pulse_start(rkey());
        run_to(5'd20, ok);
        rn = 1'b0;
        #1;
        tests_run++;
        if (rk_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rnd !== 5'd0 ||
            kreg_act !== 1'b0 || rk_out !== 64'h0) begin
            fails++;
            $display("FAIL reset_mid: vld=%b busy=%b done=%b rnd=%0d act=%b key=%h required all 0",
                     rk_vld, busy, done, rnd, kreg_act, rk_out);
        end
        @(negedge ck);
        rn = 1'b1;
        pulse_start(rkey());
        run_keys(1'b0, 1'b1);
    endtask

`ifdef KSCHD_LASTKEY_EN
    task automatic test_lastkey();
        logic [79:0] held;
        pulse_start(80'h0);
        run_keys(1'b0, 1'b1);
        held = gold_last;
        tests_run++;
        if (last_key !== held) begin
            fails++;
            $display("FAIL lastkey: last_key=%h required=%h", last_key, held);
        end
        pulse_start(rkey());
        repeat (5) @(negedge ck);
        do_abort();
        tests_run++;
        if (last_key !== held) begin
            fails++;
            $display("FAIL lastkey_abort: last_key=%h required=%h", last_key, held);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_known_vector();
        test_full();
        test_stall();
        test_abort_restart();
        test_reset_midrun();
`ifdef KSCHD_LASTKEY_EN
        test_lastkey();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
